// File: rtl/nmi_arb_pkg.sv
// Shared types and constants for the two-master nmi arbiter.
package nmi_arb_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_CPU  = 2'b01;
  localparam logic [1:0] GNT_DMA  = 2'b10;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_CPU,
    ARB_BUSY_DMA
  } arb_state_e;

  // Request payload a master holds stable until it sees ready.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } nmi_req_t;

endpackage

// File: rtl/nmi_arb_wdt.sv
// Busy-cycle watchdog: counts enabled cycles and flags the last allowed one.
module nmi_arb_wdt #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_c_o
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  // Value seen in the final busy cycle; meaningless (and unused) when disabled.
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_c_o = (TIMEOUT_CYC != 0) && en_i && (cnt_q == LAST_CNT);

endmodule

// File: rtl/nmi_arb2.sv
// Round-robin arbiter merging the CPU and DMA nmi masters onto one nmi bus,
// with a watchdog that completes transactions nobody acknowledges.
module nmi_arb2
  import nmi_arb_pkg::*;
#(
  parameter int unsigned       TIMEOUT_CYC = 256,
  parameter logic [DATA_W-1:0] ERR_RDATA   = ERR_RDATA_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  // CPU request port
  input  logic              cpu_nmi_valid_i,
  input  logic [ADDR_W-1:0] cpu_nmi_addr_i,
  input  logic [DATA_W-1:0] cpu_nmi_wdata_i,
  input  logic [STRB_W-1:0] cpu_nmi_wstrb_i,
  output logic              cpu_nmi_ready_o,
  output logic [DATA_W-1:0] cpu_nmi_rdata_o,
  // DMA request port
  input  logic              dma_nmi_valid_i,
  input  logic [ADDR_W-1:0] dma_nmi_addr_i,
  input  logic [DATA_W-1:0] dma_nmi_wdata_i,
  input  logic [STRB_W-1:0] dma_nmi_wstrb_i,
  output logic              dma_nmi_ready_o,
  output logic [DATA_W-1:0] dma_nmi_rdata_o,
  // Merged downstream bus
  output logic              mst_nmi_valid_o,
  output logic [ADDR_W-1:0] mst_nmi_addr_o,
  output logic [DATA_W-1:0] mst_nmi_wdata_o,
  output logic [STRB_W-1:0] mst_nmi_wstrb_o,
  input  logic              mst_nmi_ready_i,
  input  logic [DATA_W-1:0] mst_nmi_rdata_i,
  // Status
  output logic [1:0]        grant_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] err_addr_o,
  input  logic              err_clr_i
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant_q, grant_d;
  logic [1:0]        last_grant_q, last_grant_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic              wdt_clr, wdt_en, wdt_expire_c;
  nmi_req_t          cpu_req, dma_req, src_req;
  logic              src_valid;
  logic [1:0]        own_gnt;
  logic              own_ready;
  logic [DATA_W-1:0] own_rdata;

  assign cpu_req = {cpu_nmi_addr_i, cpu_nmi_wdata_i, cpu_nmi_wstrb_i};
  assign dma_req = {dma_nmi_addr_i, dma_nmi_wdata_i, dma_nmi_wstrb_i};

  nmi_arb_wdt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wdt (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (wdt_clr),
    .en_i       (wdt_en),
    .expire_c_o (wdt_expire_c)
  );

  // Next-state, bus routing and completion (normal or watchdog) logic.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    err_d           = err_q;
    err_addr_d      = err_addr_q;
    wdt_clr         = 1'b0;
    wdt_en          = 1'b0;
    src_valid       = 1'b0;
    src_req         = '0;
    own_gnt         = GNT_NONE;
    own_ready       = 1'b0;
    own_rdata       = '0;
    mst_nmi_valid_o = 1'b0;
    mst_nmi_addr_o  = '0;
    mst_nmi_wdata_o = '0;
    mst_nmi_wstrb_o = '0;
    cpu_nmi_ready_o = 1'b0;
    cpu_nmi_rdata_o = '0;
    dma_nmi_ready_o = 1'b0;
    dma_nmi_rdata_o = '0;

    // A timeout later in this block overrides the clear.
    if (err_clr_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      ARB_IDLE: begin
        wdt_clr = 1'b1;
        if (cpu_nmi_valid_i && (!dma_nmi_valid_i || (last_grant_q == GNT_DMA))) begin
          state_d = ARB_BUSY_CPU;
        end else if (dma_nmi_valid_i) begin
          state_d = ARB_BUSY_DMA;
        end
      end
      ARB_BUSY_CPU, ARB_BUSY_DMA: begin
        wdt_en = 1'b1;
        if (state_q == ARB_BUSY_DMA) begin
          src_valid = dma_nmi_valid_i;
          src_req   = dma_req;
          own_gnt   = GNT_DMA;
        end else begin
          src_valid = cpu_nmi_valid_i;
          src_req   = cpu_req;
          own_gnt   = GNT_CPU;
        end
        mst_nmi_valid_o = src_valid;
        mst_nmi_addr_o  = src_req.addr;
        mst_nmi_wdata_o = src_req.wdata;
        mst_nmi_wstrb_o = src_req.wstrb;
        if (!src_valid) begin
          // Owner abandoned its request: drop it silently.
          state_d = ARB_IDLE;
        end else if (mst_nmi_ready_i) begin
          own_ready    = 1'b1;
          own_rdata    = mst_nmi_rdata_i;
          last_grant_d = own_gnt;
          state_d      = ARB_IDLE;
        end else if (wdt_expire_c) begin
          mst_nmi_valid_o = 1'b0;
          own_ready       = 1'b1;
          own_rdata       = ERR_RDATA;
          err_d           = 1'b1;
          err_addr_d      = src_req.addr;
          last_grant_d    = own_gnt;
          state_d         = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (state_q == ARB_BUSY_CPU) begin
      cpu_nmi_ready_o = own_ready;
      cpu_nmi_rdata_o = own_rdata;
    end
    if (state_q == ARB_BUSY_DMA) begin
      dma_nmi_ready_o = own_ready;
      dma_nmi_rdata_o = own_rdata;
    end

    case (state_d)
      ARB_BUSY_CPU: grant_d = GNT_CPU;
      ARB_BUSY_DMA: grant_d = GNT_DMA;
      default:      grant_d = GNT_NONE;
    endcase
  end

  // State and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= ARB_IDLE;
      grant_q      <= GNT_NONE;
      last_grant_q <= GNT_DMA;
      err_q        <= 1'b0;
      err_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
      err_addr_q   <= err_addr_d;
    end
  end

  assign grant_o    = grant_q;
  assign err_o      = err_q;
  assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_nmi_arb2.sv
// Directed bench for nmi_arb2 with hand-computed expectations.
module tb_nmi_arb2;
  import nmi_arb_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, dma_valid, mst_valid, mst_ready;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [3:0]  cpu_wstrb, dma_wstrb, mst_wstrb;
  logic        cpu_ready, dma_ready;
  logic [31:0] cpu_rdata, dma_rdata, mst_addr, mst_wdata, mst_rdata;
  logic [1:0]  grant;
  logic        err, err_clr;
  logic [31:0] err_addr;

  int checks = 0;
  int failures = 0;
  int cpu_pulses = 0;
  int dma_pulses = 0;

  always #5 clk = ~clk;

  nmi_arb2 #(.TIMEOUT_CYC(TO), .ERR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_nmi_valid_i(cpu_valid), .cpu_nmi_addr_i(cpu_addr), .cpu_nmi_wdata_i(cpu_wdata),
    .cpu_nmi_wstrb_i(cpu_wstrb), .cpu_nmi_ready_o(cpu_ready), .cpu_nmi_rdata_o(cpu_rdata),
    .dma_nmi_valid_i(dma_valid), .dma_nmi_addr_i(dma_addr), .dma_nmi_wdata_i(dma_wdata),
    .dma_nmi_wstrb_i(dma_wstrb), .dma_nmi_ready_o(dma_ready), .dma_nmi_rdata_o(dma_rdata),
    .mst_nmi_valid_o(mst_valid), .mst_nmi_addr_o(mst_addr), .mst_nmi_wdata_o(mst_wdata),
    .mst_nmi_wstrb_o(mst_wstrb), .mst_nmi_ready_i(mst_ready), .mst_nmi_rdata_i(mst_rdata),
    .grant_o(grant), .err_o(err), .err_addr_o(err_addr), .err_clr_i(err_clr)
  );

  // Count ready pulses seen by each master.
  always @(negedge clk) begin
    if (cpu_ready) cpu_pulses++;
    if (dma_ready) dma_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int         pc, pd, cl, dl, gi;
    logic [1:0] exp_g;
    logic [31:0] exp_rd;

    rst_n = 1'b0; err_clr = 1'b0;
    cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
    dma_valid = 1'b0; dma_addr = '0; dma_wdata = '0; dma_wstrb = '0;
    mst_ready = 1'b0; mst_rdata = '0;
    #3;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_addr", err_addr, 0);
    chk("rst_mst_valid", 32'(mst_valid), 0);
    chk("rst_cpu_ready", 32'(cpu_ready), 0);
    chk("rst_dma_ready", 32'(dma_ready), 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ties after reset alternate CPU, DMA, CPU, DMA with a same-cycle slave.
    pc = cpu_pulses; pd = dma_pulses; cl = 2; dl = 2; gi = 0;
    for (int cyc = 0; cyc < 20 && gi < 4; cyc++) begin
      step();
      mst_ready = 1'b0; mst_rdata = '0;
      cpu_valid = (cl > 0); cpu_addr = 32'h0000_1000 + 32'(cl);
      dma_valid = (dl > 0); dma_addr = 32'h0000_2000 + 32'(dl);
      #1;
      if (mst_valid) begin
        exp_g  = (gi % 2 == 0) ? GNT_CPU : GNT_DMA;
        exp_rd = 32'hA000_0000 + 32'(gi);
        mst_ready = 1'b1; mst_rdata = exp_rd;
        #1;
        chk("t2_grant", 32'(grant), 32'(exp_g));
        chk("t2_mst_addr", mst_addr, (exp_g == GNT_CPU) ? 32'h0000_1000 + 32'(cl) : 32'h0000_2000 + 32'(dl));
        chk("t2_own_rdata", (exp_g == GNT_CPU) ? cpu_rdata : dma_rdata, exp_rd);
        chk("t2_other_ready", 32'((exp_g == GNT_CPU) ? dma_ready : cpu_ready), 0);
        if (exp_g == GNT_CPU) cl--; else dl--;
        gi++;
      end
    end
    step();
    cpu_valid = 1'b0; dma_valid = 1'b0; mst_ready = 1'b0; mst_rdata = '0;
    #1;
    step();
    chk("t2_grant_count", 32'(gi), 4);
    chk("t2_cpu_pulses", 32'(cpu_pulses - pc), 2);
    chk("t2_dma_pulses", 32'(dma_pulses - pd), 2);

    // CPU-only read, slave answers two cycles after valid.
    pc = cpu_pulses; pd = dma_pulses;
    cpu_valid = 1'b1; cpu_addr = 32'h0000_0100; cpu_wstrb = 4'h0; #1;
    chk("t1_idle_grant", 32'(grant), 0);
    chk("t1_idle_valid", 32'(mst_valid), 0);
    step(); #1;
    chk("t1_b1_grant", 32'(grant), 32'(GNT_CPU));
    chk("t1_b1_valid", 32'(mst_valid), 1);
    chk("t1_b1_addr", mst_addr, 32'h0000_0100);
    step(); #1;
    chk("t1_b2_grant", 32'(grant), 32'(GNT_CPU));
    chk("t1_b2_ready", 32'(cpu_ready), 0);
    step();
    mst_ready = 1'b1; mst_rdata = 32'h1234_5678; #1;
    chk("t1_b3_grant", 32'(grant), 32'(GNT_CPU));
    chk("t1_b3_ready", 32'(cpu_ready), 1);
    chk("t1_b3_rdata", cpu_rdata, 32'h1234_5678);
    chk("t1_b3_dma_rdata", dma_rdata, 0);
    step();
    cpu_valid = 1'b0; mst_ready = 1'b0; mst_rdata = '0; #1;
    chk("t1_after_grant", 32'(grant), 0);
    step();
    chk("t1_cpu_pulses", 32'(cpu_pulses - pc), 1);
    chk("t1_dma_pulses", 32'(dma_pulses - pd), 0);

    // Unmapped CPU read: watchdog completes it in busy cycle TO.
    cpu_valid = 1'b1; cpu_addr = 32'h7000_0000; #1;
    for (int k = 1; k <= int'(TO); k++) begin
      step(); #1;
      if (k < int'(TO)) begin
        chk("t3_wait_ready", 32'(cpu_ready), 0);
      end else begin
        chk("t3_wdt_ready", 32'(cpu_ready), 1);
        chk("t3_wdt_rdata", cpu_rdata, 32'hDEAD_BEEF);
        chk("t3_wdt_valid", 32'(mst_valid), 0);
      end
    end
    step();
    cpu_valid = 1'b0; #1;
    chk("t3_err", 32'(err), 1);
    chk("t3_err_addr", err_addr, 32'h7000_0000);
    chk("t3_grant_idle", 32'(grant), 0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0; #1;
    chk("t3_err_cleared", 32'(err), 0);
    chk("t3_err_addr_kept", err_addr, 32'h7000_0000);

    // Slave ready lands exactly in the expiry cycle: normal completion.
    cpu_valid = 1'b1; cpu_addr = 32'h7000_0004; #1;
    for (int k = 1; k <= int'(TO); k++) begin
      step();
      if (k == int'(TO)) begin
        mst_ready = 1'b1; mst_rdata = 32'hA5A5_0001;
      end
      #1;
      if (k == int'(TO)) begin
        chk("t4_ready", 32'(cpu_ready), 1);
        chk("t4_rdata", cpu_rdata, 32'hA5A5_0001);
        chk("t4_valid", 32'(mst_valid), 1);
      end
    end
    step();
    cpu_valid = 1'b0; mst_ready = 1'b0; mst_rdata = '0; #1;
    chk("t4_no_err", 32'(err), 0);
    chk("t4_err_addr", err_addr, 32'h7000_0000);

    // Reset mid BUSY_DMA, then a pending tie must go to the CPU.
    dma_valid = 1'b1; dma_addr = 32'h4000_0000; dma_wstrb = 4'h0; #1;
    step();
    cpu_valid = 1'b1; cpu_addr = 32'h0000_0500; #1;
    chk("t5_busy_dma", 32'(grant), 32'(GNT_DMA));
    rst_n = 1'b0; #1;
    chk("t5_rst_grant", 32'(grant), 0);
    chk("t5_rst_valid", 32'(mst_valid), 0);
    chk("t5_rst_addr", mst_addr, 0);
    chk("t5_rst_dma_ready", 32'(dma_ready), 0);
    chk("t5_rst_err_addr", err_addr, 0);
    #2 rst_n = 1'b1;
    step(); #1;
    chk("t5_tie_cpu", 32'(grant), 32'(GNT_CPU));
    mst_ready = 1'b1; mst_rdata = 32'h0000_0055; #1;
    chk("t5_cpu_ready", 32'(cpu_ready), 1);
    step();
    cpu_valid = 1'b0; mst_ready = 1'b0; #1;
    step(); #1;
    chk("t5_then_dma", 32'(grant), 32'(GNT_DMA));
    mst_ready = 1'b1; mst_rdata = 32'h0000_0066; #1;
    chk("t5_dma_rdata", dma_rdata, 32'h0000_0066);
    step();
    dma_valid = 1'b0; mst_ready = 1'b0; mst_rdata = '0; #1;

    // DMA write held on the bus while a CPU request waits behind it.
    step();
    dma_valid = 1'b1; dma_addr = 32'h2000_0040; dma_wdata = 32'hCAFE_F00D; dma_wstrb = 4'hF; #1;
    step();
    cpu_valid = 1'b1; cpu_addr = 32'h0000_0300; cpu_wdata = '0; cpu_wstrb = 4'h0; #1;
    chk("t6_grant_dma", 32'(grant), 32'(GNT_DMA));
    chk("t6_addr1", mst_addr, 32'h2000_0040);
    chk("t6_wdata1", mst_wdata, 32'hCAFE_F00D);
    chk("t6_wstrb1", 32'(mst_wstrb), 32'hF);
    step(); #1;
    chk("t6_addr2", mst_addr, 32'h2000_0040);
    chk("t6_cpu_wait", 32'(cpu_ready), 0);
    mst_ready = 1'b1; mst_rdata = '0; #1;
    chk("t6_dma_ready", 32'(dma_ready), 1);
    chk("t6_cpu_no_ready", 32'(cpu_ready), 0);
    step();
    dma_valid = 1'b0; mst_ready = 1'b0; #1;
    chk("t6_idle_grant", 32'(grant), 0);
    chk("t6_idle_wdata", mst_wdata, 0);
    step(); #1;
    chk("t6_grant_cpu", 32'(grant), 32'(GNT_CPU));
    chk("t6_cpu_addr", mst_addr, 32'h0000_0300);
    mst_ready = 1'b1; mst_rdata = 32'h0000_0077; #1;
    chk("t6_cpu_rdata", cpu_rdata, 32'h0000_0077);
    step();
    cpu_valid = 1'b0; mst_ready = 1'b0; mst_rdata = '0; #1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nmi_arb2.md
Name: nmi_arb2

Overview:
- Two-master to one-slave arbiter for the native memory interface (nmi).
- Merges the CPU nmi and the DMA engine's master port (`dma_nmi` of the native IP wrapper) into the single nmi bus that feeds the native IP wrapper and memories.
- Round-robin arbitration; one grant held per transaction.
- Built-in watchdog: completes any transaction that no slave acknowledges (unmapped address), so neither master can hang the bus.

Parameters:
- TIMEOUT_CYC, 256, cycles in a busy state before the watchdog completes the transaction; 0 disables the watchdog.
- ERR_RDATA, 32'hDEAD_BEEF, rdata returned on a watchdog completion.

Ports:
- clk_i  input  1  system clock.
- rst_n_i  input  1  asynchronous active-low reset.
- cpu_nmi  nmi_if.slave  -  CPU request port (valid/addr[31:0]/wdata[31:0]/wstrb[3:0] in; ready/rdata[31:0] out).
- dma_nmi  nmi_if.slave  -  DMA request port (same signals).
- mst_nmi  nmi_if.master  -  merged downstream bus to the wrapper.
- grant_o  output  2  one-hot current owner: [0] CPU, [1] DMA; 0 when idle.
- err_o  output  1  sticky watchdog error flag.
- err_addr_o  output  32  address of the last timed-out transaction.
- err_clr_i  input  1  single-cycle pulse that clears err_o.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is asynchronous, active-low, on rst_n_i.
- nmi protocol:
  - Master holds valid, addr, wdata and wstrb stable until it sees ready.
  - ready is a one-cycle pulse; rdata is valid only while ready = 1.
  - wstrb = 0 means read.
- State machine, 3 states: IDLE, BUSY_CPU, BUSY_DMA.
- IDLE:
  - mst_nmi.valid = 0; both slave readies = 0.
  - Only CPU valid -> BUSY_CPU. Only DMA valid -> BUSY_DMA.
  - Both valid -> grant the master not recorded in last_grant.
  - The grant register updates at the clock edge; watchdog counter cleared.
- BUSY_x:
  - mst_nmi valid/addr/wdata/wstrb driven combinationally from master x.
  - mst_nmi.ready and rdata routed only to master x; the other master sees ready = 0 and rdata = 0.
  - On mst_nmi.ready: last_grant <= x, next state IDLE.
- Latency: request seen in cycle N; forwarded in cycle N+1; with a same-cycle-ready slave, the master sees ready in N+1. Back-to-back throughput is 1 transaction per 2 cycles (mandatory IDLE cycle).
- Watchdog:
  - Counter width is $clog2(TIMEOUT_CYC+1); it increments every BUSY cycle.
  - When count == TIMEOUT_CYC-1 and mst_nmi.ready = 0, the arbiter itself pulses ready to master x with rdata = ERR_RDATA.
  - In that cycle: mst_nmi.valid forced 0; err_o <= 1; err_addr_o <= addr; last_grant <= x; next state IDLE.
- Simultaneous events:
  - mst_nmi.ready in the watchdog cycle -> normal completion, no error.
  - err_clr_i in the same cycle as a new timeout -> set wins.
- Master drops valid while BUSY (protocol violation): return to IDLE next cycle, no ready, last_grant unchanged, no error.
- Reset, including mid-transaction: state IDLE; last_grant = DMA, so the CPU wins the first tie.
- Reset output values: grant_o = 0, err_o = 0, err_addr_o = 0, mst_nmi.valid = 0, cpu/dma ready = 0, rdata = 0.
- Combinational outputs while IDLE: mst_nmi.addr, wdata and wstrb driven 0.

Decomposition:
- Package nmi_arb_pkg holds:
  - state enum arb_state_e {ARB_IDLE, ARB_BUSY_CPU, ARB_BUSY_DMA};
  - grant constants GNT_CPU = 2'b01, GNT_DMA = 2'b10;
  - default ERR_RDATA.
- One natural sub-module, nmi_arb_wdt: watchdog counter with clr/en inputs and an expire output, TIMEOUT_CYC parameter, disabled at 0.

Test Plan:
- CPU-only read, slave ready asserted 2 cycles after mst valid -> cpu ready pulses once with slave rdata 32'h1234_5678; grant_o = 01 for 3 cycles, then 00; dma ready stays 0.
- CPU and DMA valid in the same cycle after reset, repeated 4 times with a 1-cycle slave -> grants alternate CPU, DMA, CPU, DMA; each master gets exactly 2 ready pulses.
- CPU read to an unmapped address 32'h7000_0000, no slave ready, TIMEOUT_CYC = 16 -> cpu ready in busy cycle 16 with rdata 32'hDEAD_BEEF; err_o = 1; err_addr_o = 32'h7000_0000; err_clr_i pulse then clears err_o.
- Slave ready arrives exactly in the watchdog expiry cycle -> normal rdata delivered, err_o stays 0.
- Reset asserted mid BUSY_DMA -> all outputs go to reset values immediately; after release, a pending CPU and DMA tie grants CPU first.
- DMA write (wstrb = 4'hF) while CPU valid arrives one cycle later -> mst_nmi carries the DMA addr/wdata unchanged until ready; CPU granted in the cycle after the IDLE cycle.
